// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio -- data-side memory system for a single-cycle CPU.
//
// Decodes each data-bus access into either a word-addressed data RAM with
// byte write enables or a small MMIO page (LED register, buffered 8N1 UART
// transmitter, free-running cycle counter). Reads are combinational, writes
// commit at the rising clock edge.
//
// Ports:
//   clk      in   1   system clock, all state updates on rising edge
//   reset    in   1   synchronous, active-high
//   daddr    in  32   byte address (bits [1:0] ignored)
//   dwdata   in  32   lane-aligned write data
//   dwe      in   4   per-byte write enables
//   drdata   out 32   combinational read data for daddr
//   leds     out  8   LED register
//   uart_tx  out  1   UART serial output, idle high
//
// MMIO map (base 0x8000_0000): 0x0 LED, 0x4 UART data/status,
// 0x8 cycle counter (read-only), 0xC reserved (reads 0).
// -----------------------------------------------------------------------------
module dmem_mmio #(
  parameter int RAM_WORDS  = 1024,
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1'b1);
  localparam logic [FW-1:0] PTR_ONE   = FW'(1'b1);
  localparam logic [FW:0]   CNT_ONE   = (FW+1)'(1'b1);
  localparam logic [FW:0]   CNT_FULL  = (FW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [31:0]   r_mem [RAM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_wptr;
  logic [FW-1:0] r_rptr;
  logic [FW:0]   r_count;
  logic [7:0]    r_leds;
  logic [31:0]   r_cycle;
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          w_ram_sel;
  logic          w_mmio_sel;
  logic [AW-1:0] w_ram_idx;
  logic [1:0]    w_mmio_off;
  logic          w_led_we;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_busy;
  logic          w_baud_end;
  logic          w_unused;

  assign w_ram_sel  = (daddr[31] == 1'b0);
  assign w_mmio_sel = (daddr[31:4] == 28'h8000000);
  assign w_ram_idx  = daddr[AW+1:2];
  assign w_mmio_off = daddr[3:2];
  // Byte offset within a word has no meaning on this bus.
  assign w_unused   = ^daddr[1:0];

  assign w_led_we   = w_mmio_sel && (w_mmio_off == 2'd0) && dwe[0];
  assign w_push_req = w_mmio_sel && (w_mmio_off == 2'd1) && dwe[0];

  assign w_empty    = (r_count == {(FW+1){1'b0}});
  assign w_full     = (r_count == CNT_FULL);
  assign w_busy     = (r_state != ST_IDLE) || !w_empty;
  assign w_baud_end = (r_baud == BAUD_LAST);

  // A push while full is still accepted when the transmitter pops in the
  // same cycle, so occupancy never exceeds the depth.
  assign w_push     = w_push_req && (!w_full || w_pop);

  assign leds    = r_leds;
  assign uart_tx = r_tx;

  // Pop request: the transmitter takes a byte when idle or at the end of a stop bit.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = !w_empty;
      ST_STOP: w_pop = w_baud_end && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  // Combinational read mux over RAM and MMIO; unmapped addresses read zero.
  always_comb begin
    drdata = 32'd0;
    if (w_ram_sel) begin
      drdata = r_mem[w_ram_idx];
    end else if (w_mmio_sel) begin
      case (w_mmio_off)
        2'd0:    drdata = {24'd0, r_leds};
        2'd1:    drdata = {30'd0, w_full, w_busy};
        2'd2:    drdata = r_cycle;
        default: drdata = 32'd0;
      endcase
    end else begin
      drdata = 32'd0;
    end
  end

  // Data RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) begin
          r_mem[w_ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
        end
      end
    end
  end

  // LED register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds <= 8'd0;
    end else if (w_led_we) begin
      r_leds <= dwdata[7:0];
    end
  end

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // FIFO storage; entries need no reset because the count gates their use.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_fifo[r_wptr] <= dwdata[7:0];
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= {FW{1'b0}};
      r_rptr  <= {FW{1'b0}};
      r_count <= {(FW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // UART transmit FSM. The line register follows the current state, so the
  // serial output trails the state by one cycle; every bit keeps its full
  // BAUD_DIV length and back-to-back frames stay gap-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_baud  <= {BW{1'b0}};
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= {BW{1'b0}};
          if (w_pop) begin
            r_shift <= r_fifo[r_rptr];
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_tx <= 1'b0;
          if (w_baud_end) begin
            r_baud  <= {BW{1'b0}};
            r_bit   <= 3'd0;
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        ST_DATA: begin
          r_tx <= r_shift[0];
          if (w_baud_end) begin
            r_baud  <= {BW{1'b0}};
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_end) begin
            r_baud <= {BW{1'b0}};
            if (w_pop) begin
              r_shift <= r_fifo[r_rptr];
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_baud  <= {BW{1'b0}};
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio -- self-checking bench for dmem_mmio.
//
// A behavioural model tracks RAM words, LED value, cycle count and the UART as
// a byte queue plus the times at which the transmitter takes each byte; the
// expected serial level is derived from those times and the frame format.
// Directed sequences cover the listed scenarios, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_dmem_mmio;

  localparam int RW = 64;
  localparam int BD = 4;
  localparam int FD = 8;
  localparam int AW = $clog2(RW);
  localparam int FRAME = 10 * BD;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [7:0]  leds;
  logic        uart_tx;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_mmio #(.RAM_WORDS(RW), .BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .leds(leds), .uart_tx(uart_tx)
  );

  initial forever #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit [31:0] m_mem [RW];
  bit [3:0]  m_vld [RW];
  bit [7:0]  m_leds;
  bit [31:0] m_cnt;
  bit [7:0]  m_q [$];
  int        t_edge = 0;
  bit        have_pop = 1'b0, have_prev = 1'b0;
  int        last_pop, prev_pop;
  bit [7:0]  last_byte, prev_byte;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return (m_q.size() > 0) || (have_pop && (t_edge < last_pop + FRAME));
  endfunction

  // Level of the frame for byte b taken at edge p, as seen after edge t_edge.
  function automatic bit [1:0] frame_level(int p, bit [7:0] b);
    int d;
    int k;
    d = t_edge - p - 1;
    if (d < 0 || d >= FRAME) return 2'b00;
    k = d / BD;
    if (k == 0) return 2'b10;
    if (k <= 8) return {1'b1, b[k-1]};
    return 2'b11;
  endfunction

  function automatic bit exp_tx();
    bit [1:0] v;
    if (have_pop) begin
      v = frame_level(last_pop, last_byte);
      if (v[1]) return v[0];
    end
    if (have_prev) begin
      v = frame_level(prev_pop, prev_byte);
      if (v[1]) return v[0];
    end
    return 1'b1;
  endfunction

  function automatic void model_read(input bit [31:0] a, output bit ok, output bit [31:0] v);
    int idx;
    ok = 1'b1;
    v  = 32'd0;
    if (a[31] == 1'b0) begin
      idx = int'(a[AW+1:2]);
      ok  = (m_vld[idx] == 4'hF);
      v   = m_mem[idx];
    end else if (a[31:4] == 28'h8000000) begin
      case (a[3:2])
        2'd0:    v = {24'd0, m_leds};
        2'd1:    v = {30'd0, (m_q.size() == FD), m_busy()};
        2'd2:    v = m_cnt;
        default: v = 32'd0;
      endcase
    end
  endfunction

  function automatic void model_step(bit [31:0] a, bit [31:0] wd, bit [3:0] we, bit rst);
    int sz;
    bit pop;
    int idx;
    t_edge++;
    if (a[31] == 1'b0) begin
      idx = int'(a[AW+1:2]);
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          m_mem[idx][8*i +: 8] = wd[8*i +: 8];
          m_vld[idx][i] = 1'b1;
        end
      end
    end
    if (rst) begin
      m_leds = 8'd0;
      m_cnt  = 32'd0;
      m_q.delete();
      have_pop  = 1'b0;
      have_prev = 1'b0;
    end else begin
      m_cnt++;
      sz  = m_q.size();
      pop = (sz > 0) && (!have_pop || t_edge >= last_pop + FRAME);
      if (pop) begin
        prev_pop  = last_pop;
        prev_byte = last_byte;
        have_prev = have_pop;
        last_pop  = t_edge;
        last_byte = m_q.pop_front();
        have_pop  = 1'b1;
      end
      if (a[31:4] == 28'h8000000 && a[3:2] == 2'd1 && we[0] && (sz < FD || pop))
        m_q.push_back(wd[7:0]);
      if (a[31:4] == 28'h8000000 && a[3:2] == 2'd0 && we[0])
        m_leds = wd[7:0];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick(logic [31:0] a, logic [31:0] wd, logic [3:0] we, logic rst);
    bit        ok;
    bit [31:0] v;
    reset = rst; daddr = a; dwdata = wd; dwe = we;
    #1;
    model_read(a, ok, v);
    if (ok) check_eq("rdata", drdata, v);
    @(posedge clk);
    model_step(a, wd, we, rst);
    @(negedge clk);
    check_eq("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx()});
    check_eq("leds", {24'd0, leds}, {24'd0, m_leds});
  endtask

  task automatic peek(string tag, logic [31:0] a, logic [31:0] e);
    daddr = a; dwe = 4'h0;
    #1;
    check_eq(tag, drdata, e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && m_busy(); i++) tick(32'h80000004, 32'd0, 4'h0, 1'b0);
    peek("idle_status", 32'h80000004, 32'd0);
  endtask

  bit        s [42];
  bit        sq [$];
  bit [9:0]  lv = 10'b1010101010;
  bit [7:0]  rb;
  int        nb, start_prev, ii;
  bit [31:0] r1, r2;
  int        rsel;

  initial begin
    reset = 1'b1; daddr = 32'd0; dwdata = 32'd0; dwe = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(32'h80000000, 32'd0, 4'h0, 1'b1);

    // Reset state
    peek("rst_status", 32'h80000004, 32'd0);
    check_eq("rst_leds", {24'd0, leds}, 32'd0);
    check_eq("rst_tx", {31'd0, uart_tx}, 32'd1);

    // RAM byte lanes and aliasing
    tick(32'h00000010, 32'hAABBCCDD, 4'hF, 1'b0);
    tick(32'h00000010, 32'h00000011, 4'h1, 1'b0);
    peek("ram_lane", 32'h00000010, 32'hAABBCC11);
    peek("ram_alias", 32'h00000010 + RW * 4, 32'hAABBCC11);

    // LED and decode
    tick(32'h80000000, 32'h000001A5, 4'hF, 1'b0);
    check_eq("led_val", {24'd0, leds}, 32'h000000A5);
    peek("led_read", 32'h80000000, 32'h000000A5);
    tick(32'h80000010, 32'h000000FF, 4'hF, 1'b0);
    check_eq("led_hold", {24'd0, leds}, 32'h000000A5);
    peek("unmapped", 32'h80000010, 32'd0);
    peek("mmio_c", 32'h8000000C, 32'd0);

    // Single UART frame of 0x55
    wait_idle();
    tick(32'h80000004, 32'h00000055, 4'h1, 1'b0);
    for (int j = 0; j < 42; j++) begin
      tick(32'h80000004, 32'd0, 4'h0, 1'b0);
      s[j] = uart_tx;
      if (j == 20) peek("frame_busy", 32'h80000004, 32'h1);
    end
    peek("frame_done", 32'h80000004, 32'h0);
    for (int j = 0; j < 42; j++)
      check_eq("frame_bit", {31'd0, s[j]},
               {31'd0, (j == 0 || j == 41) ? 1'b1 : lv[(j-1)/BD]});

    // FIFO full, overflow drop and back-to-back frames
    wait_idle();
    sq.delete();
    for (int i = 1; i <= 10; i++) begin
      tick(32'h80000004, i, 4'h1, 1'b0);
      sq.push_back(uart_tx);
    end
    peek("fifo_full", 32'h80000004, 32'h3);
    tick(32'h80000004, 32'h000000EE, 4'h1, 1'b0);
    sq.push_back(uart_tx);
    for (int i = 0; i < 9 * FRAME + 10; i++) begin
      tick(32'h80000004, 32'd0, 4'h0, 1'b0);
      sq.push_back(uart_tx);
    end
    nb = 0; start_prev = 0; ii = 1;
    while (ii < sq.size()) begin
      if (sq[ii-1] && !sq[ii] && (ii + 38 < sq.size())) begin
        for (int k = 0; k < 8; k++) rb[k] = sq[ii + BD * (k + 1) + BD / 2];
        check_eq("rx_byte", {24'd0, rb}, nb + 1);
        if (nb > 0) check_eq("rx_gap", ii - start_prev, FRAME);
        start_prev = ii;
        nb++;
        ii += FRAME;
      end else begin
        ii++;
      end
    end
    check_eq("rx_count", nb, 9);

    // Cycle counter
    tick(32'h80000008, 32'd0, 4'h0, 1'b1);
    for (int i = 0; i < 5; i++) tick(32'h80000008, 32'd0, 4'hF, 1'b0);
    peek("cnt_n", 32'h80000008, 32'd5);
    force dut.r_cycle = 32'hFFFFFFFE;
    #1;
    release dut.r_cycle;
    m_cnt = 32'hFFFFFFFE;
    peek("cnt_forced", 32'h80000008, 32'hFFFFFFFE);
    tick(32'h80000008, 32'd0, 4'h0, 1'b0);
    peek("cnt_max", 32'h80000008, 32'hFFFFFFFF);
    tick(32'h80000008, 32'd0, 4'h0, 1'b0);
    peek("cnt_wrap", 32'h80000008, 32'h00000000);

    // Reset in the middle of a frame
    tick(32'h80000000, 32'h0000003C, 4'h1, 1'b0);
    tick(32'h00000040, 32'hCAFEF00D, 4'hF, 1'b0);
    wait_idle();
    tick(32'h80000004, 32'h000000C3, 4'h1, 1'b0);
    for (int i = 0; i < 17; i++) tick(32'h80000004, 32'd0, 4'h0, 1'b0);
    tick(32'h80000004, 32'd0, 4'h0, 1'b1);
    check_eq("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    check_eq("mid_rst_leds", {24'd0, leds}, 32'd0);
    reset = 1'b0;
    peek("mid_rst_status", 32'h80000004, 32'd0);
    peek("mid_rst_cnt", 32'h80000008, 32'd0);
    peek("mid_rst_ram", 32'h00000040, 32'hCAFEF00D);

    // Randomized traffic against the model
    for (int n = 0; n < 2500; n++) begin
      rsel = $urandom_range(0, 99);
      r1 = $urandom();
      r2 = $urandom();
      if (rsel < 25) begin
        r1[31] = 1'b0;
        tick(r1, r2, 4'($urandom_range(0, 15)), 1'b0);
      end else if (rsel < 45) begin
        r1[31] = 1'b0;
        tick(r1, r2, 4'h0, 1'b0);
      end else if (rsel < 52) begin
        tick(32'h80000000, r2, 4'($urandom_range(0, 15)), 1'b0);
      end else if (rsel < 64) begin
        tick(32'h80000004, r2, 4'($urandom_range(0, 15)) | 4'h1, 1'b0);
      end else if (rsel < 80) begin
        tick(32'h80000000 | (32'($urandom_range(0, 3)) << 2), r2,
             4'($urandom_range(0, 15)), 1'b0);
      end else if (rsel < 85) begin
        r1[31] = 1'b1;
        if (r1[31:4] == 28'h8000000) r1[4] = 1'b1;
        tick(r1, r2, 4'($urandom_range(0, 15)), 1'b0);
      end else if (rsel == 85) begin
        tick(32'h80000004, 32'd0, 4'h0, 1'b1);
      end else begin
        tick(32'h80000004, 32'd0, 4'h0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
